// File: rtl/stroke_sequencer.sv
// Stroke sequencer: walks a digit's stroke ROM segment by segment, driving the pen servo and
// handing each segment to the line-motion controller. Optional macro PEN_SETTLE_EN adds the servo settle wait.
module stroke_sequencer #(
  parameter int unsigned IDX_W         = 5,
  parameter int unsigned COORD_W       = 8,
  parameter int unsigned SETTLE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [IDX_W-1:0]   seg_count,
  output logic [IDX_W-1:0]   rom_idx,
  output logic               rom_en,
  input  logic [COORD_W-1:0] rom_start_x,
  input  logic [COORD_W-1:0] rom_start_y,
  input  logic [COORD_W-1:0] rom_end_x,
  input  logic [COORD_W-1:0] rom_end_y,
  input  logic               rom_pen_down,
  output logic               pen_cmd,
  output logic               mv_valid,
  input  logic               mv_ready,
  output logic [COORD_W-1:0] mv_x0,
  output logic [COORD_W-1:0] mv_y0,
  output logic [COORD_W-1:0] mv_x1,
  output logic [COORD_W-1:0] mv_y1,
  input  logic               mv_done,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETTLE = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] count;
  logic             last_seg;
  logic             pen_change;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  assign last_seg   = (rom_idx == count - IDX_W'(1));
  assign pen_change = (rom_pen_down != pen_cmd);

`ifdef PEN_SETTLE_EN
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [CNT_W-1:0] settle_cnt;

  // Loaded on the FETCH edge so SETTLE lasts exactly SETTLE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == FETCH && pen_change) begin
      settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (state == SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rom_en    = 1'b0;
    mv_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && seg_count != '0) state_nxt = FETCH;
      end
      FETCH: begin
        rom_en = 1'b1;
`ifdef PEN_SETTLE_EN
        state_nxt = pen_change ? SETTLE : ISSUE;
`else
        state_nxt = ISSUE;
`endif
      end
`ifdef PEN_SETTLE_EN
      SETTLE: begin
        if (settle_cnt == '0) state_nxt = ISSUE;
      end
`endif
      ISSUE: begin
        mv_valid = 1'b1;
        if (mv_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (mv_done) state_nxt = last_seg ? FINISH : FETCH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) state_nxt = IDLE;
  end

  // done is registered, so it lands in FINISH (or the cycle after a zero-length start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      rom_idx <= '0;
      pen_cmd <= 1'b0;
      mv_x0   <= '0;
      mv_y0   <= '0;
      mv_x1   <= '0;
      mv_y1   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        rom_idx <= '0;
        pen_cmd <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (seg_count != '0) begin
                count   <= seg_count;
                rom_idx <= '0;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FETCH: begin
            mv_x0   <= rom_start_x;
            mv_y0   <= rom_start_y;
            mv_x1   <= rom_end_x;
            mv_y1   <= rom_end_y;
            pen_cmd <= rom_pen_down;
          end
          WAIT: begin
            if (mv_done) begin
              if (last_seg) begin
                done    <= 1'b1;
                pen_cmd <= 1'b0;
              end else begin
                rom_idx <= rom_idx + IDX_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stroke_sequencer.sv
// Testbench for stroke_sequencer: directed and randomized drawings checked against a
// segment-level timing model (settle wait modelled only when PEN_SETTLE_EN is defined).
module tb_stroke_sequencer;

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned COORD_W = 8;
  localparam int          SETTLE  = 4;
`ifdef PEN_SETTLE_EN
  localparam bit SETTLE_EN = 1'b1;
`else
  localparam bit SETTLE_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               mv_ready = 1'b0;
  logic               mv_done = 1'b0;
  logic [IDX_W-1:0]   seg_count = '0;
  logic [IDX_W-1:0]   rom_idx;
  logic               rom_en;
  logic [COORD_W-1:0] rom_start_x, rom_start_y, rom_end_x, rom_end_y;
  logic               rom_pen_down;
  logic               pen_cmd, mv_valid, busy, done;
  logic [COORD_W-1:0] mv_x0, mv_y0, mv_x1, mv_y1;

  logic [COORD_W-1:0] tsx [32];
  logic [COORD_W-1:0] tsy [32];
  logic [COORD_W-1:0] tex [32];
  logic [COORD_W-1:0] tey [32];
  logic               tpen[32];

  int vectors = 0;
  int miscompares = 0;

  assign rom_start_x  = tsx[rom_idx];
  assign rom_start_y  = tsy[rom_idx];
  assign rom_end_x    = tex[rom_idx];
  assign rom_end_y    = tey[rom_idx];
  assign rom_pen_down = tpen[rom_idx];

  stroke_sequencer #(
    .IDX_W        (IDX_W),
    .COORD_W      (COORD_W),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .seg_count   (seg_count),
    .rom_idx     (rom_idx),
    .rom_en      (rom_en),
    .rom_start_x (rom_start_x),
    .rom_start_y (rom_start_y),
    .rom_end_x   (rom_end_x),
    .rom_end_y   (rom_end_y),
    .rom_pen_down(rom_pen_down),
    .pen_cmd     (pen_cmd),
    .mv_valid    (mv_valid),
    .mv_ready    (mv_ready),
    .mv_x0       (mv_x0),
    .mv_y0       (mv_y0),
    .mv_x1       (mv_x1),
    .mv_y1       (mv_y1),
    .mv_done     (mv_done),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx"},   32'(rom_idx), 0);
    chk({tag, "_en"},    32'(rom_en), 0);
    chk({tag, "_pen"},   32'(pen_cmd), 0);
    chk({tag, "_valid"}, 32'(mv_valid), 0);
    chk({tag, "_coord"}, {mv_x0, mv_y0, mv_x1, mv_y1}, 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  task automatic chk_seg(input string tag, input int i);
    chk({tag, "_x0"}, 32'(mv_x0), 32'(tsx[i]));
    chk({tag, "_y0"}, 32'(mv_y0), 32'(tsy[i]));
    chk({tag, "_x1"}, 32'(mv_x1), 32'(tex[i]));
    chk({tag, "_y1"}, 32'(mv_y1), 32'(tey[i]));
  endtask

  task automatic load_two;
    logic [COORD_W-1:0] sx [7] = '{0,   60,  60,  120, 180, 60,  180};
    logic [COORD_W-1:0] sy [7] = '{0,   40,  120, 160, 120, 40,  120};
    logic [COORD_W-1:0] ex [7] = '{60,  60,  120, 180, 60,  180, 0};
    logic [COORD_W-1:0] ey [7] = '{40,  120, 160, 120, 40,  120, 0};
    logic               pn [7] = '{0,   1,   1,   1,   1,   1,   0};
    for (int i = 0; i < 7; i++) begin
      tsx[i] = sx[i]; tsy[i] = sy[i]; tex[i] = ex[i]; tey[i] = ey[i]; tpen[i] = pn[i];
    end
  endtask

  task automatic load_random;
    for (int i = 0; i < 32; i++) begin
      tsx[i]  = COORD_W'($urandom);
      tsy[i]  = COORD_W'($urandom);
      tex[i]  = COORD_W'($urandom);
      tey[i]  = COORD_W'($urandom);
      tpen[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Segment-level model: each segment is FETCH, optional settle, ISSUE until handshake, WAIT until mv_done.
  task automatic draw(input int n, input int slow_seg, input int abort_at);
    logic exp_pen;
    int   settle, d, w;
    exp_pen   = 1'b0;
    seg_count = IDX_W'(n);
    start     = 1'b1;
    tick;
    start     = 1'b0;
    seg_count = IDX_W'($urandom);
    for (int i = 0; i < n; i++) begin
      chk("fetch_en",    32'(rom_en), 1);
      chk("fetch_idx",   32'(rom_idx), 32'(i));
      chk("fetch_valid", 32'(mv_valid), 0);
      chk("fetch_busy",  32'(busy), 1);
      mv_done = 1'($urandom_range(0, 1));
      tick;
      mv_done = 1'b0;
      settle = 0;
      if (tpen[i] != exp_pen) begin
        exp_pen = tpen[i];
        if (SETTLE_EN) settle = SETTLE;
      end
      chk("pen_after_fetch", 32'(pen_cmd), 32'(exp_pen));
      if (i == abort_at) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy",  32'(busy), 0);
        chk("abort_pen",   32'(pen_cmd), 0);
        chk("abort_valid", 32'(mv_valid), 0);
        chk("abort_idx",   32'(rom_idx), 0);
        chk("abort_done",  32'(done), 0);
        tick;
        chk("abort_done2", 32'(done), 0);
        return;
      end
      for (int s = 0; s < settle; s++) begin
        chk("settle_valid", 32'(mv_valid), 0);
        chk("settle_en",    32'(rom_en), 0);
        tick;
      end
      d = (i == slow_seg) ? 10 : int'($urandom_range(0, 3));
      for (int k = 0; k < d; k++) begin
        chk("stall_valid", 32'(mv_valid), 1);
        chk_seg("stall", i);
        mv_done = 1'($urandom_range(0, 1));
        tick;
        mv_done = 1'b0;
      end
      chk("issue_valid", 32'(mv_valid), 1);
      chk_seg("issue", i);
      mv_ready = 1'b1;
      mv_done  = 1'($urandom_range(0, 1));
      tick;
      mv_ready = 1'b0;
      mv_done  = 1'b0;
      chk("wait_valid", 32'(mv_valid), 0);
      chk("wait_idx",   32'(rom_idx), 32'(i));
      w = int'($urandom_range(0, 3));
      for (int k = 0; k < w; k++) begin
        start     = 1'($urandom_range(0, 1));
        seg_count = IDX_W'($urandom);
        tick;
        start = 1'b0;
        chk("wait_busy", 32'(busy), 1);
        chk("wait_hold_idx", 32'(rom_idx), 32'(i));
      end
      mv_done = 1'b1;
      tick;
      mv_done = 1'b0;
    end
    chk("finish_done", 32'(done), 1);
    chk("finish_pen",  32'(pen_cmd), 0);
    chk("finish_busy", 32'(busy), 1);
    tick;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_en",   32'(rom_en), 0);
  endtask

  initial begin
    load_two();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk_all_zero("post_reset");

    mv_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("idle_spurious_idx",  32'(rom_idx), 0);
      chk("idle_spurious_busy", 32'(busy), 0);
    end
    mv_done = 1'b0;

    seg_count = '0;
    start     = 1'b1;
    tick;
    start = 1'b0;
    chk("zero_done",  32'(done), 1);
    chk("zero_busy",  32'(busy), 0);
    chk("zero_en",    32'(rom_en), 0);
    tick;
    chk("zero_done2", 32'(done), 0);
    chk("zero_en2",   32'(rom_en), 0);

    draw(7, 1, -1);
    draw(7, -1, 1);
    draw(7, -1, -1);

    seg_count = IDX_W'(7);
    start     = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("pre_reset_valid", 32'(mv_valid), 1);
    chk("pre_reset_x1",    32'(mv_x1), 60);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk_all_zero("after_async_reset");

    for (int r = 0; r < 12; r++) begin
      load_random();
      draw(int'($urandom_range(1, 8)), int'($urandom_range(0, 8)), -1);
    end
    load_random();
    draw(31, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
